// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencing controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_LW,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_ILLEGAL,
    S_HALT
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    SB_B      = 2'b00,
    SB_FOUR   = 2'b01,
    SB_IMM    = 2'b10,
    SB_IMM_SH = 2'b11
  } alu_srcb_e;

  // AS_NONE leaves the ALU operation bus at 000 in states that do not use the ALU.
  typedef enum logic [1:0] {
    AS_NONE = 2'b00,
    AS_ADD  = 2'b01,
    AS_SUB  = 2'b10,
    AS_FUNC = 2'b11
  } alu_sel_e;

  typedef struct packed {
    logic      mem_req;
    logic      mem_read;
    logic      mem_write;
    logic      iord;
    logic      ir_write;
    logic      pc_write;
    logic      reg_write;
    reg_dst_e  reg_dst;
    logic      mem_to_reg;
    logic      wd_inp;
    logic      alu_src_a;
    alu_srcb_e alu_src_b;
    alu_sel_e  alu_sel;
    pc_src_e   pc_src;
    logic      retire;
  } ctrl_t;

  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decode: fixed add/sub, or derived from func (R-type) / opcode (slti).
module mc_alu_decoder
  import mc_pkg::*;
(
  input  alu_sel_e   sel,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  output logic [2:0] alu_op
);

  alu_op_e op;

  always_comb begin
    op = ALU_AND;
    unique case (sel)
      AS_NONE: op = ALU_AND;
      AS_ADD:  op = ALU_ADD;
      AS_SUB:  op = ALU_SUB;
      AS_FUNC: begin
        op = ALU_ADD;
        if (opc == OP_SLTI) begin
          op = ALU_SLT;
        end else if (opc == OP_RTYPE) begin
          case (func)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
          endcase
        end
      end
      default: op = ALU_AND;
    endcase
  end

  assign alu_op = op;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencing FSM with memory handshake watchdog.
// Define MC_ILLEGAL_TRAP_EN to trap illegal opcodes into a HALT state.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       MemToReg,
  output logic       WDInp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic       retire,
  output logic       mem_timeout,
  output logic       halted
);

  localparam int unsigned CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_e        state;
  state_e        state_next;
  ctrl_t         c;
  logic [2:0]    alu_op;
  logic [CW-1:0] wd_cnt;
  logic          wd_wait;
  logic          wd_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    c          = '0;
    state_next = state;
    unique case (state)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SB_FOUR;
        c.alu_sel   = AS_ADD;
        c.pc_src    = PC_ALU;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_b = SB_IMM_SH;
        c.alu_sel   = AS_ADD;
        case (opc)
          OP_RTYPE:        state_next = (func == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_SLTI: state_next = S_EXEC_I;
          OP_LW, OP_SW:    state_next = S_MEM_ADDR;
          OP_BEQ:          state_next = S_BRANCH;
          OP_J:            state_next = S_JUMP;
          OP_JAL:          state_next = S_JAL;
          default:         state_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SB_B;
        c.alu_sel   = AS_FUNC;
        state_next  = S_WB_R;
      end
      S_WB_R: begin
        // func-derived operation stays on the bus through R-type write-back
        c.reg_write = 1'b1;
        c.reg_dst   = RD_RD;
        c.alu_sel   = AS_FUNC;
        c.retire    = 1'b1;
        state_next  = S_FETCH;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SB_IMM;
        c.alu_sel   = AS_FUNC;
        state_next  = S_WB_I;
      end
      S_WB_I: begin
        c.reg_write = 1'b1;
        c.reg_dst   = RD_RT;
        c.retire    = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SB_IMM;
        c.alu_sel   = AS_ADD;
        state_next  = (opc == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready) begin
          state_next = S_WB_LW;
        end
      end
      S_WB_LW: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RD_RT;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        if (mem_ready) begin
          c.retire   = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SB_B;
        c.alu_sel   = AS_SUB;
        c.pc_src    = PC_ALUOUT;
        c.pc_write  = zero;
        c.retire    = 1'b1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        c.pc_src   = PC_JUMP;
        c.pc_write = 1'b1;
        c.retire   = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        c.pc_src    = PC_JUMP;
        c.pc_write  = 1'b1;
        c.reg_write = 1'b1;
        c.reg_dst   = RD_RA;
        c.wd_inp    = 1'b1;
        c.retire    = 1'b1;
        state_next  = S_FETCH;
      end
      S_JR: begin
        c.pc_src   = PC_REG;
        c.pc_write = 1'b1;
        c.retire   = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        state_next = S_HALT;
`else
        c.retire   = 1'b1;
        state_next = S_FETCH;
`endif
      end
      S_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
        state_next = S_HALT;
`else
        state_next = S_FETCH;
`endif
      end
      default: state_next = S_FETCH;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .sel    (c.alu_sel),
    .opc    (opc),
    .func   (func),
    .alu_op (alu_op)
  );

  // The pulse fires in the cycle after WAIT_LIMIT consecutive stalls; that cycle
  // is itself a stall, so it opens the next window with the count at one.
  assign wd_wait = is_mem_wait(state) && !mem_ready;
  assign wd_hit  = (WAIT_LIMIT != 0) && wd_wait && (wd_cnt == CW'(WAIT_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (WAIT_LIMIT == 0 || !wd_wait) begin
      wd_cnt <= '0;
    end else if (wd_hit) begin
      wd_cnt <= CW'(1);
    end else begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  // Every output is held low while reset is asserted.
  assign mem_req      = rst & c.mem_req;
  assign MemRead      = rst & c.mem_read;
  assign MemWrite     = rst & c.mem_write;
  assign IorD         = rst & c.iord;
  assign IRWrite      = rst & c.ir_write;
  assign PCWrite      = rst & c.pc_write;
  assign RegWrite     = rst & c.reg_write;
  assign RegDst       = {2{rst}} & c.reg_dst;
  assign MemToReg     = rst & c.mem_to_reg;
  assign WDInp        = rst & c.wd_inp;
  assign ALUSrcA      = rst & c.alu_src_a;
  assign ALUSrcB      = {2{rst}} & c.alu_src_b;
  assign ALUOperation = {3{rst}} & alu_op;
  assign PCSrc        = {2{rst}} & c.pc_src;
  assign retire       = rst & c.retire;
  assign mem_timeout  = rst & wd_hit;

`ifdef MC_ILLEGAL_TRAP_EN
  assign halted = rst & (state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control words.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req, rd, wr, iord, irw, pcw, regw;
    logic [1:0] regdst;
    logic       m2r, wdinp, srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       retire, timeout, halted;
  } ov_t;

  typedef struct {
    logic       rdy;
    logic       z;
    logic [5:0] opc;
    logic [5:0] fn;
    ov_t        exp;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] opc = '0;
  logic [5:0] func = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite;
  logic [1:0] RegDst, ALUSrcB, PCSrc;
  logic MemToReg, WDInp, ALUSrcA, retire, mem_timeout, halted;
  logic [2:0] ALUOperation;
  ov_t act;

  stim_t sq[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .WDInp(WDInp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOperation(ALUOperation), .PCSrc(PCSrc), .retire(retire),
    .mem_timeout(mem_timeout), .halted(halted)
  );

  assign act = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, RegDst,
                MemToReg, WDInp, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, retire,
                mem_timeout, halted};

  function automatic ov_t e_fetch(input logic r, input logic to);
    ov_t e = '0;
    e.mem_req = 1'b1; e.rd = 1'b1; e.srcb = 2'b01; e.aluop = 3'b010;
    e.irw = r; e.pcw = r; e.timeout = to;
    return e;
  endfunction

  function automatic ov_t e_decode();
    ov_t e = '0;
    e.srcb = 2'b11; e.aluop = 3'b010;
    return e;
  endfunction

  function automatic ov_t e_exec(input logic [1:0] srcb, input logic [2:0] op);
    ov_t e = '0;
    e.srca = 1'b1; e.srcb = srcb; e.aluop = op;
    return e;
  endfunction

  function automatic ov_t e_wb(input logic [1:0] dst, input logic [2:0] op, input logic m2r);
    ov_t e = '0;
    e.regw = 1'b1; e.regdst = dst; e.aluop = op; e.m2r = m2r; e.retire = 1'b1;
    return e;
  endfunction

  function automatic ov_t e_mem(input logic wr, input logic done);
    ov_t e = '0;
    e.mem_req = 1'b1; e.rd = !wr; e.wr = wr; e.iord = 1'b1; e.retire = wr & done;
    return e;
  endfunction

  function automatic ov_t e_branch(input logic z);
    ov_t e = '0;
    e.srca = 1'b1; e.srcb = 2'b00; e.aluop = 3'b110; e.pcsrc = 2'b01;
    e.pcw = z; e.retire = 1'b1;
    return e;
  endfunction

  function automatic ov_t e_jump(input logic link, input logic jr);
    ov_t e = '0;
    e.pcsrc = jr ? 2'b11 : 2'b10; e.pcw = 1'b1; e.retire = 1'b1;
    e.regw = link; e.regdst = link ? 2'b10 : 2'b00; e.wdinp = link;
    return e;
  endfunction

  task automatic push(input logic rdy, input logic z, input logic [5:0] o,
                      input logic [5:0] f, input ov_t exp);
    stim_t s;
    s.rdy = rdy; s.z = z; s.opc = o; s.fn = f; s.exp = exp;
    sq.push_back(s);
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; opc = 6'b100011;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (act !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h required %h", act, ov_t'('0));
      end
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_rtype();
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    stim_t s;
    int cyc = 0;
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 1'b0, 6'b000000, fns[i], e_fetch(1'b1, 1'b0));
      push(1'b0, 1'b1, 6'b000000, fns[i], e_decode());
      push(1'b0, 1'b1, 6'b000000, fns[i], e_exec(2'b00, ops[i]));
      push(1'b1, 1'b0, 6'b000000, fns[i], e_wb(2'b01, ops[i], 1'b0));
    end
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL rtype step %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype();
    stim_t s;
    int cyc = 0;
    push(1'b1, 1'b0, 6'b001000, 6'b111111, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b001000, 6'b111111, e_decode());
    push(1'b1, 1'b0, 6'b001000, 6'b111111, e_exec(2'b10, 3'b010));
    push(1'b1, 1'b0, 6'b001000, 6'b111111, e_wb(2'b00, 3'b000, 1'b0));
    push(1'b1, 1'b0, 6'b001010, 6'b100000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b001010, 6'b100000, e_decode());
    push(1'b1, 1'b0, 6'b001010, 6'b100000, e_exec(2'b10, 3'b111));
    push(1'b1, 1'b0, 6'b001010, 6'b100000, e_wb(2'b00, 3'b000, 1'b0));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL itype step %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    stim_t s;
    int cyc = 0;
    push(1'b1, 1'b0, 6'b100011, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b100011, 6'b000000, e_decode());
    push(1'b1, 1'b0, 6'b100011, 6'b000000, e_exec(2'b10, 3'b010));
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 6'b100011, 6'b000000, e_mem(1'b0, 1'b0));
    push(1'b1, 1'b0, 6'b100011, 6'b000000, e_mem(1'b0, 1'b1));
    push(1'b1, 1'b0, 6'b100011, 6'b000000, e_wb(2'b00, 3'b000, 1'b1));
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_decode());
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_exec(2'b10, 3'b010));
    push(1'b0, 1'b0, 6'b101011, 6'b000000, e_mem(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_mem(1'b1, 1'b1));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL load_store step %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s;
    int cyc = 0;
    for (int i = 0; i < 2; i++) begin
      push(1'b1, 1'b0, 6'b000100, 6'b000000, e_fetch(1'b1, 1'b0));
      push(1'b1, 1'b0, 6'b000100, 6'b000000, e_decode());
      push(1'b1, (i == 0), 6'b000100, 6'b000000, e_branch(i == 0));
    end
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL branch step %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    stim_t s;
    int cyc = 0;
    push(1'b1, 1'b0, 6'b000010, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b0, 1'b0, 6'b000010, 6'b000000, e_decode());
    push(1'b0, 1'b1, 6'b000010, 6'b000000, e_jump(1'b0, 1'b0));
    push(1'b1, 1'b0, 6'b000011, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b000011, 6'b000000, e_decode());
    push(1'b1, 1'b0, 6'b000011, 6'b000000, e_jump(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b000000, 6'b001000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b000000, 6'b001000, e_decode());
    push(1'b1, 1'b0, 6'b000000, 6'b001000, e_jump(1'b0, 1'b1));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL jumps step %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    int cyc = 0;
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_decode());
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_exec(2'b10, 3'b010));
    push(1'b1, 1'b0, 6'b101011, 6'b000000, e_mem(1'b1, 1'b1));
    push(1'b0, 1'b0, 6'b000000, 6'b100010, e_fetch(1'b0, 1'b0));
    push(1'b1, 1'b0, 6'b000000, 6'b100010, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b000000, 6'b100010, e_decode());
    push(1'b1, 1'b0, 6'b000000, 6'b100010, e_exec(2'b00, 3'b110));
    push(1'b1, 1'b0, 6'b000000, 6'b100010, e_wb(2'b01, 3'b110, 1'b0));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    stim_t s;
    int cyc = 0;
    for (int i = 1; i <= 31; i++)
      push(1'b0, 1'b0, 6'b000010, 6'b000000, e_fetch(1'b0, (i == 16) || (i == 31)));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL watchdog_stall cycle %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL watchdog_reset_outputs: got %h required %h", act, ov_t'('0));
    end
    @(posedge clk); #1 rst = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 15; i++) push(1'b0, 1'b0, 6'b000010, 6'b000000, e_fetch(1'b0, 1'b0));
    push(1'b1, 1'b0, 6'b000010, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b000010, 6'b000000, e_decode());
    push(1'b1, 1'b0, 6'b000010, 6'b000000, e_jump(1'b0, 1'b0));
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL watchdog_limit_vs_ready cycle %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    stim_t s;
    ov_t e;
    int cyc = 0;
    push(1'b1, 1'b0, 6'b111111, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b111111, 6'b000000, e_decode());
`ifdef MC_ILLEGAL_TRAP_EN
    push(1'b1, 1'b0, 6'b111111, 6'b000000, ov_t'('0));
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 6'b000010, 6'b000000, e);
`else
    e = '0; e.retire = 1'b1;
    push(1'b1, 1'b0, 6'b111111, 6'b000000, e);
    push(1'b1, 1'b0, 6'b000010, 6'b000000, e_fetch(1'b1, 1'b0));
    push(1'b1, 1'b0, 6'b000010, 6'b000000, e_decode());
    push(1'b1, 1'b0, 6'b000010, 6'b000000, e_jump(1'b0, 1'b0));
`endif
    while (sq.size() != 0) begin
      s = sq.pop_front();
      mem_ready = s.rdy; zero = s.z; opc = s.opc; func = s.fn; cyc++;
      @(negedge clk);
      n_checks++;
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL illegal step %0d: got %h required %h", cyc, act, s.exp);
      end
      @(posedge clk); #1;
    end
`ifdef MC_ILLEGAL_TRAP_EN
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL halt_reset_outputs: got %h required %h", act, ov_t'('0));
    end
    @(posedge clk); #1 rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (act !== e_fetch(1'b1, 1'b0)) begin
      n_fail++;
      $display("FAIL halt_release_fetch: got %h required %h", act, e_fetch(1'b1, 1'b0));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load_store();
    test_branch();
    test_jumps();
    test_back_to_back();
    test_watchdog();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL run_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
